pq_sorted_array: RTL and testbench

- Parametrised successor to the two-input compare/route element: a register-based sorted priority queue of DEPTH entries.
- Every entry owns one compare/route cell, so the best key is always available at the head with zero read latency.
- Supports push, pop, and a simultaneous push+pop ("replace"), each completing in one cycle.
- Sits between the key producer and the BRAM-backed overflow store in the QuickQ datapath.

---
 rtl/pq_pkg.sv | 31 +++
 rtl/pq_sorted_array_if.sv | 30 +++
 rtl/pq_cell.sv | 88 ++++++++
 rtl/pq_sorted_array.sv | 119 +++++++++++
 tb/tb_pq_sorted_array.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/pq_pkg.sv
// Shared types and the key comparison used by every priority-queue cell.
//   pq_op_t   : per-cycle operation broadcast from the top to all cells
//   pq_better : strict "a ranks ahead of b" test, direction and signedness
//               selected by the caller
// Keys are passed widened to PQ_MAX_W bits. The caller sign- or zero-extends
// them first, so one function serves every key width up to PQ_MAX_W.
package pq_pkg;

  typedef enum logic [1:0] {
    PQ_NONE,
    PQ_PUSH,
    PQ_POP,
    PQ_REPLACE
  } pq_op_t;

  localparam int PQ_MAX_W = 64;

  function automatic logic pq_better(input logic [PQ_MAX_W-1:0] a,
                                     input logic [PQ_MAX_W-1:0] b,
                                     input logic                max_first,
                                     input logic                signed_cmp);
    logic r;
    if (signed_cmp) begin
      r = max_first ? ($signed(a) > $signed(b)) : ($signed(a) < $signed(b));
    end else begin
      r = max_first ? (a > b) : (a < b);
    end
    return r;
  endfunction

endpackage

// File: rtl/pq_sorted_array_if.sv
// Handshake and status bundle of the sorted priority queue.
//   master : key producer / consumer side (drives push_valid, push_data, pop)
//   slave  : the queue (drives push_ready, head_*, count, full, empty, drop)
interface pq_sorted_array_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;
  logic              pop;
  logic [DATA_W-1:0] head_data;
  logic              head_valid;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              drop;

  modport master (
    output push_valid, push_data, pop,
    input  push_ready, head_data, head_valid, count, full, empty, drop
  );

  modport slave (
    input  push_valid, push_data, pop,
    output push_ready, head_data, head_valid, count, full, empty, drop
  );
endinterface

// File: rtl/pq_cell.sv
// One entry of the sorted array together with its compare/route logic.
//   clk, rst_n           : clock, synchronous active-low reset
//   op                   : operation for this cycle (same for all cells)
//   new_key              : key being inserted
//   left_val/left_vld    : entry i-1 (constant invalid for entry 0)
//   right_val/right_vld  : entry i+1 (constant invalid past the tail)
//   left_ins             : insert flag of entry i-1 (0 for entry 0)
//   ins                  : this entry's insert flag
//   val/vld              : registered entry
module pq_cell
  import pq_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MAX_FIRST  = 1,
  parameter int SIGNED_CMP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  pq_op_t            op,
  input  logic [DATA_W-1:0] new_key,
  input  logic [DATA_W-1:0] left_val,
  input  logic              left_vld,
  input  logic [DATA_W-1:0] right_val,
  input  logic              right_vld,
  input  logic              left_ins,
  output logic              ins,
  output logic [DATA_W-1:0] val,
  output logic              vld
);

  logic [DATA_W-1:0] cmp_val;
  logic              cmp_vld;
  logic [DATA_W-1:0] nxt_val;
  logic              nxt_vld;

  function automatic logic [PQ_MAX_W-1:0] widen(input logic [DATA_W-1:0] x);
    logic [PQ_MAX_W-1:0] r;
    r = '0;
    if ((SIGNED_CMP != 0) && x[DATA_W-1]) r = '1;
    r[DATA_W-1:0] = x;
    return r;
  endfunction

  // A replace sees the array already shifted left by one, so the cell
  // compares against its right neighbour and its own entry becomes s[i-1].
  // The strict compare places a new key behind existing equal keys.
  always_comb begin
    cmp_val = (op == PQ_REPLACE) ? right_val : val;
    cmp_vld = (op == PQ_REPLACE) ? right_vld : vld;
    ins     = ~cmp_vld | pq_better(widen(new_key), widen(cmp_val),
                                   MAX_FIRST != 0, SIGNED_CMP != 0);
    nxt_val = val;
    nxt_vld = vld;
    case (op)
      PQ_PUSH: begin
        if (ins) begin
          nxt_val = left_ins ? left_val : new_key;
          nxt_vld = left_ins ? left_vld : 1'b1;
        end
      end
      PQ_POP: begin
        nxt_val = right_val;
        nxt_vld = right_vld;
      end
      PQ_REPLACE: begin
        if (ins) begin
          nxt_val = left_ins ? val : new_key;
          nxt_vld = left_ins ? vld : 1'b1;
        end else begin
          nxt_val = right_val;
          nxt_vld = right_vld;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val <= '0;
      vld <= 1'b0;
    end else begin
      val <= nxt_val;
      vld <= nxt_vld;
    end
  end

endmodule

// File: rtl/pq_sorted_array.sv
// Register-based sorted priority queue of DEPTH entries. Entry 0 is always
// the best key, so the head is read with zero latency. Push, pop and
// push+pop (replace) each complete in one cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : pq_sorted_array_if.slave
//                push_valid/push_data/push_ready : insert handshake
//                pop                             : remove head
//                head_data/head_valid            : best key (0 when empty)
//                count/full/empty                : occupancy
//                drop : registered one-cycle pulse after a pop hits an empty queue
module pq_sorted_array
  import pq_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 8,
  parameter int MAX_FIRST  = 1,
  parameter int SIGNED_CMP = 0
) (
  input  logic clk,
  input  logic rst_n,
  pq_sorted_array_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH:0][DATA_W-1:0] val;
  logic [DEPTH:0]             vld;
  logic [DEPTH-1:0]           ins;
  logic                       tail_ins_unused;

  logic [CW-1:0] count_q;
  logic          drop_q;
  logic          empty;
  logic          full;
  logic          pop_fire;
  logic          push_ready;
  logic          push_fire;
  pq_op_t        op;

  // Slot past the tail reads as an invalid, zero entry.
  assign val[DEPTH] = '0;
  assign vld[DEPTH] = 1'b0;

  // The last cell has no right neighbour consuming its insert flag.
  assign tail_ins_unused = ins[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic [DATA_W-1:0] lval;
    logic              lvld;
    logic              lins;

    if (i == 0) begin : g_first
      assign lval = '0;
      assign lvld = 1'b0;
      assign lins = 1'b0;
    end else begin : g_rest
      assign lval = val[i-1];
      assign lvld = vld[i-1];
      assign lins = ins[i-1];
    end

    pq_cell #(
      .DATA_W    (DATA_W),
      .MAX_FIRST (MAX_FIRST),
      .SIGNED_CMP(SIGNED_CMP)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .op       (op),
      .new_key  (bus.push_data),
      .left_val (lval),
      .left_vld (lvld),
      .right_val(val[i+1]),
      .right_vld(vld[i+1]),
      .left_ins (lins),
      .ins      (ins[i]),
      .val      (val[i]),
      .vld      (vld[i])
    );
  end

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign pop_fire   = bus.pop & ~empty;
  assign push_ready = ~full | pop_fire;
  assign push_fire  = bus.push_valid & push_ready;

  always_comb begin
    case ({push_fire, pop_fire})
      2'b10:   op = PQ_PUSH;
      2'b01:   op = PQ_POP;
      2'b11:   op = PQ_REPLACE;
      default: op = PQ_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= bus.pop & empty;
      case (op)
        PQ_PUSH: count_q <= count_q + CW'(1);
        PQ_POP:  count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  assign bus.push_ready = push_ready;
  assign bus.head_data  = val[0];
  assign bus.head_valid = vld[0];
  assign bus.count      = count_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.drop       = drop_q;

endmodule

// File: tb/tb_pq_sorted_array.sv
module tb_pq_sorted_array;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0: 32-bit unsigned, largest first; dut1: 8-bit signed, smallest first
  pq_sorted_array_if #(.DATA_W(32), .DEPTH(4)) if0 ();
  pq_sorted_array_if #(.DATA_W(8),  .DEPTH(4)) if1 ();

  pq_sorted_array #(.DATA_W(32), .DEPTH(4), .MAX_FIRST(1), .SIGNED_CMP(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  pq_sorted_array #(.DATA_W(8), .DEPTH(4), .MAX_FIRST(0), .SIGNED_CMP(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int vectors = 0;
  int errors  = 0;

  // Reference model for dut0: an ordered list of keys, head at index 0.
  int unsigned mq[$];
  logic        exp_ready;
  logic        exp_drop;
  logic        pend_pop;
  logic        pend_push;
  int unsigned pend_key;

  function automatic void model_insert(input int unsigned k);
    int p = 0;
    while (p < mq.size() && !(k > mq[p])) p++;
    mq.insert(p, k);
  endfunction

  task automatic set0(input logic pv, input logic [31:0] pd, input logic pp);
    if0.push_valid = pv;
    if0.push_data  = pd;
    if0.pop        = pp;
    pend_pop  = pp && (mq.size() > 0);
    exp_ready = (mq.size() < 4) || pend_pop;
    pend_push = pv && exp_ready;
    pend_key  = pd;
    exp_drop  = pp && (mq.size() == 0);
  endtask

  task automatic clk0();
    @(posedge clk);
    #1;
    if (pend_pop) void'(mq.pop_front());
    if (pend_push) model_insert(pend_key);
    if0.push_valid = 1'b0;
    if0.push_data  = '0;
    if0.pop        = 1'b0;
  endtask

  task automatic step1(input logic pv, input logic [7:0] pd, input logic pp);
    if1.push_valid = pv;
    if1.push_data  = pd;
    if1.pop        = pp;
    @(posedge clk);
    #1;
    if1.push_valid = 1'b0;
    if1.push_data  = '0;
    if1.pop        = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vectors++; if (if0.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", if0.count); end
    vectors++; if (if0.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", if0.empty); end
    vectors++; if (if0.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", if0.full); end
    vectors++; if (if0.head_valid !== 1'b0) begin errors++; $display("FAIL reset_head_valid: got %b want 0", if0.head_valid); end
    vectors++; if (if0.head_data !== 32'd0) begin errors++; $display("FAIL reset_head_data: got %0h want 0", if0.head_data); end
    vectors++; if (if0.drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", if0.drop); end
    vectors++; if (if1.empty !== 1'b1) begin errors++; $display("FAIL reset_empty1: got %b want 1", if1.empty); end
  endtask

  task automatic test_push_pop();
    int unsigned exp_c[3] = '{9, 5, 3};
    set0(1'b1, 32'd5, 1'b0); clk0();
    set0(1'b1, 32'd9, 1'b0); clk0();
    set0(1'b1, 32'd3, 1'b0); clk0();
    vectors++; if (if0.head_data !== 32'd9) begin errors++; $display("FAIL pp_head: got %0d want 9", if0.head_data); end
    vectors++; if (if0.count !== 3'd3) begin errors++; $display("FAIL pp_count: got %0d want 3", if0.count); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (dut0.val[i] !== exp_c[i]) begin errors++; $display("FAIL pp_entry%0d: got %0d want %0d", i, dut0.val[i], exp_c[i]); end
    end
    set0(1'b0, 32'd0, 1'b1); clk0();
    vectors++; if (if0.head_data !== 32'd5) begin errors++; $display("FAIL pp_pop_head: got %0d want 5", if0.head_data); end
    vectors++; if (if0.count !== 3'd2) begin errors++; $display("FAIL pp_pop_count: got %0d want 2", if0.count); end
    repeat (2) begin set0(1'b0, 32'd0, 1'b1); clk0(); end
    vectors++; if (if0.empty !== 1'b1) begin errors++; $display("FAIL pp_drain: empty got %b want 1", if0.empty); end
  endtask

  task automatic test_full_ignore();
    int unsigned exp_c[4] = '{4, 3, 2, 1};
    for (int k = 1; k <= 4; k++) begin set0(1'b1, 32'(k), 1'b0); clk0(); end
    vectors++; if (if0.full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", if0.full); end
    set0(1'b1, 32'd7, 1'b0);
    #1;
    vectors++; if (if0.push_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", if0.push_ready); end
    clk0();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dut0.val[i] !== exp_c[i]) begin errors++; $display("FAIL full_entry%0d: got %0d want %0d", i, dut0.val[i], exp_c[i]); end
    end
    vectors++; if (if0.count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", if0.count); end
  endtask

  task automatic test_replace();
    int unsigned exp_c[4] = '{3, 2, 1, 0};
    set0(1'b1, 32'd0, 1'b1);
    #1;
    vectors++; if (if0.push_ready !== 1'b1) begin errors++; $display("FAIL repl_ready: got %b want 1", if0.push_ready); end
    clk0();
    vectors++; if (if0.head_data !== 32'd3) begin errors++; $display("FAIL repl_head: got %0d want 3", if0.head_data); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dut0.val[i] !== exp_c[i] || dut0.vld[i] !== 1'b1) begin
        errors++; $display("FAIL repl_entry%0d: got %0d/%b want %0d/1", i, dut0.val[i], dut0.vld[i], exp_c[i]);
      end
    end
    vectors++; if (if0.count !== 3'd4 || if0.full !== 1'b1) begin errors++; $display("FAIL repl_count: got %0d/%b want 4/1", if0.count, if0.full); end
    repeat (4) begin set0(1'b0, 32'd0, 1'b1); clk0(); end
  endtask

  task automatic test_empty_pop();
    set0(1'b0, 32'd0, 1'b1); clk0();
    vectors++; if (if0.drop !== 1'b1) begin errors++; $display("FAIL epop_drop: got %b want 1", if0.drop); end
    vectors++; if (if0.count !== 3'd0) begin errors++; $display("FAIL epop_count: got %0d want 0", if0.count); end
    set0(1'b0, 32'd0, 1'b0); clk0();
    vectors++; if (if0.drop !== 1'b0) begin errors++; $display("FAIL epop_drop_pulse: got %b want 0", if0.drop); end
    set0(1'b1, 32'd6, 1'b1); clk0();
    vectors++; if (if0.head_data !== 32'd6) begin errors++; $display("FAIL epush_head: got %0d want 6", if0.head_data); end
    vectors++; if (if0.count !== 3'd1) begin errors++; $display("FAIL epush_count: got %0d want 1", if0.count); end
    vectors++; if (if0.drop !== 1'b1) begin errors++; $display("FAIL epush_drop: got %b want 1", if0.drop); end
    set0(1'b0, 32'd0, 1'b1); clk0();
  endtask

  task automatic test_reset_mid();
    set0(1'b1, 32'd11, 1'b0); clk0();
    set0(1'b1, 32'd22, 1'b0); clk0();
    set0(1'b1, 32'd33, 1'b0); clk0();
    rst_n = 1'b0;
    if0.push_valid = 1'b1;
    if0.push_data  = 32'd44;
    @(posedge clk);
    #1;
    mq.delete();
    rst_n = 1'b1;
    if0.push_valid = 1'b0;
    if0.push_data  = '0;
    vectors++; if (if0.count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", if0.count); end
    vectors++; if (if0.empty !== 1'b1) begin errors++; $display("FAIL rmid_empty: got %b want 1", if0.empty); end
    vectors++; if (if0.head_data !== 32'd0 || if0.head_valid !== 1'b0) begin errors++; $display("FAIL rmid_head: got %0h/%b want 0/0", if0.head_data, if0.head_valid); end
    set0(1'b0, 32'd0, 1'b0); clk0();
    vectors++; if (if0.count !== 3'd0) begin errors++; $display("FAIL rmid_after: count got %0d want 0", if0.count); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set0(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)), ($urandom_range(0, 9) < 4));
      #1;
      vectors++; if (if0.push_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, if0.push_ready, exp_ready); end
      clk0();
      vectors++; if (if0.count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, if0.count, mq.size()); end
      vectors++; if (if0.head_data !== ((mq.size() > 0) ? mq[0] : 32'd0)) begin errors++; $display("FAIL rnd_head[%0d]: got %0d want %0d", n, if0.head_data, (mq.size() > 0) ? mq[0] : 0); end
      vectors++; if (if0.head_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_hvalid[%0d]: got %b", n, if0.head_valid); end
      vectors++; if (if0.full !== (mq.size() == 4) || if0.empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_flags[%0d]: full/empty got %b/%b size %0d", n, if0.full, if0.empty, mq.size()); end
      vectors++; if (if0.drop !== exp_drop) begin errors++; $display("FAIL rnd_drop[%0d]: got %b want %b", n, if0.drop, exp_drop); end
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (dut0.vld[i] !== (i < mq.size()) || dut0.val[i] !== ((i < mq.size()) ? mq[i] : 32'd0)) begin
          errors++; $display("FAIL rnd_entry%0d[%0d]: got %0d/%b", i, n, dut0.val[i], dut0.vld[i]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if ((!dut0.vld[i] && dut0.vld[i+1]) || (dut0.vld[i+1] && dut0.val[i+1] > dut0.val[i])) begin
          errors++; $display("FAIL rnd_invariant%0d[%0d]: entries %0d/%b %0d/%b", i, n, dut0.val[i], dut0.vld[i], dut0.val[i+1], dut0.vld[i+1]);
        end
      end
    end
  endtask

  task automatic test_signed_min();
    logic [7:0] pushes[4] = '{8'hFE, 8'h05, 8'hFE, 8'hF9};
    logic [7:0] order[4]  = '{8'hF9, 8'hFE, 8'hFE, 8'h05};
    for (int i = 0; i < 4; i++) step1(1'b1, pushes[i], 1'b0);
    vectors++; if (if1.full !== 1'b1 || if1.count !== 3'd4) begin errors++; $display("FAIL sgn_fill: got %0d/%b want 4/1", if1.count, if1.full); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (if1.head_data !== order[i]) begin errors++; $display("FAIL sgn_order%0d: got %0h want %0h", i, if1.head_data, order[i]); end
      step1(1'b0, 8'h00, 1'b1);
    end
    vectors++; if (if1.empty !== 1'b1 || if1.head_data !== 8'h00) begin errors++; $display("FAIL sgn_drain: got %b/%0h want 1/0", if1.empty, if1.head_data); end
  endtask

  initial begin
    if0.push_valid = 1'b0; if0.push_data = '0; if0.pop = 1'b0;
    if1.push_valid = 1'b0; if1.push_data = '0; if1.pop = 1'b0;
    test_reset();
    test_push_pop();
    test_full_ignore();
    test_replace();
    test_empty_pop();
    test_reset_mid();
    test_random();
    test_signed_min();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
